mux_4_1_top: RTL and testbench
==============================

MUX_4_1_TOP -- requirements
Module: mux_4_1_top

Interface
REQ-001 Parameter OUT_RST, default 1'b0; value loaded into Out_reg on reset.
REQ-002 Port Clk, input, 1, single rising-edge clock.
REQ-003 Port Rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port In0, input, 1, data input selected when {Sel1,Sel0}=2'b00.
REQ-005 Port In1, input, 1, data input selected when {Sel1,Sel0}=2'b01.
REQ-006 Port In2, input, 1, data input selected when {Sel1,Sel0}=2'b10.
REQ-007 Port In3, input, 1, data input selected when {Sel1,Sel0}=2'b11.
REQ-008 Port Sel1, input, 1, select MSB.
REQ-009 Port Sel0, input, 1, select LSB.
REQ-010 Port Out_df, output, 1, combinational mux result, dataflow (continuous-assign equation) form.
REQ-011 Port Out_st, output, 1, combinational mux result, structural (gate/sub-module instance) form.
REQ-012 Port Out_bh, output, 1, combinational mux result, behavioural (case/always) form.
REQ-013 Port Out_reg, output, 1, Out_bh registered on Clk.
REQ-014 Port Mismatch, output, 1, sticky flag: the three combinational forms disagreed (present only under MUX_4_1_CHECK_EN).

Function
REQ-015 Out_df, Out_st, Out_bh SHALL each equal In[{Sel1,Sel0}], zero-latency combinational, independent of Clk and Rst_n.
REQ-016 The three combinational outputs SHALL be bit-identical for every one of the 64 binary input combinations.
REQ-017 Out_df SHALL be a single sum-of-products equation: (~Sel1&~Sel0&In0)|(~Sel1&Sel0&In1)|(Sel1&~Sel0&In2)|(Sel1&Sel0&In3).
REQ-018 Out_st SHALL be two first-level 2:1 muxes on Sel0 (In0/In1, In2/In3), then one 2:1 mux on Sel1.
REQ-019 Out_bh SHALL use a full case on {Sel1,Sel0} with a default branch driving 1'bx.
REQ-020 Out_reg SHALL capture Out_bh on each rising Clk edge; latency exactly 1 cycle.
REQ-021 Input changes between edges SHALL NOT affect Out_reg until the next rising edge.

Reset
REQ-022 Rst_n low SHALL immediately (asynchronously) force Out_reg=OUT_RST and Mismatch=0.
REQ-023 Reset SHALL NOT affect Out_df, Out_st, Out_bh.
REQ-024 Release of Rst_n SHALL be synchronised to Clk externally; first capture occurs at the first rising edge with Rst_n high.
REQ-025 Reset asserted mid-operation SHALL discard the pending capture; no glitch beyond the reset value.

Configuration
REQ-026 Macro MUX_4_1_CHECK_EN defined: Mismatch port and checker present; Mismatch sets on the rising edge where Out_df, Out_st, Out_bh differ, and stays set until reset.
REQ-027 Macro MUX_4_1_CHECK_EN undefined: Mismatch port and checker logic absent; all other behaviour unchanged.

Structure
REQ-028 Package mux_4_1_pkg SHALL hold localparams SEL_IN0=2'b00, SEL_IN1=2'b01, SEL_IN2=2'b10, SEL_IN3=2'b11, used by the behavioural case.
REQ-029 A single sub-module mux_2_1 (inputs A, B, S; output Y; Y=S?B:A) SHALL be instantiated three times for Out_st.
REQ-030 Out_df, Out_bh, the register and the checker SHALL reside in mux_4_1_top.

Verification
REQ-031 Exhaustive sweep: 6-bit counter i=0..63, Sel1=i[5], Sel0=i[4], In0=i[3], In1=i[2], In2=i[1], In3=i[0], 10 ns per step -> all three outputs equal the selected input at every step.
REQ-032 Sel=2'b10, In0..In3=1,1,0,1 -> Out_df=Out_st=Out_bh=0; after one Clk edge Out_reg=0.
REQ-033 Sel=2'b11, In3 toggles 0->1 between edges -> combinational outputs follow at once; Out_reg changes only at the next rising edge.
REQ-034 Out_reg=1, Rst_n driven low between edges -> Out_reg=OUT_RST (0) with no Clk edge; Out_df unaffected.
REQ-035 With MUX_4_1_CHECK_EN, 64-vector sweep -> Mismatch stays 0; Out_st forced to inverse for one cycle -> Mismatch=1 until Rst_n low.

Source files
------------

// File: rtl/mux_4_1_pkg.sv
// Shared select encodings for the 4:1 mux slice.
// The behavioural mux decodes {Sel1,Sel0} against these names so that the
// mapping from select value to data input lives in exactly one place.
package mux_4_1_pkg;

  localparam logic [1:0] SEL_IN0 = 2'b00;
  localparam logic [1:0] SEL_IN1 = 2'b01;
  localparam logic [1:0] SEL_IN2 = 2'b10;
  localparam logic [1:0] SEL_IN3 = 2'b11;

endpackage

// File: rtl/mux_2_1.sv
// Single-bit 2:1 multiplexer used as the building block of the structural
// 4:1 mux. Y follows B when S is high and A when S is low.
module mux_2_1 (
  input  logic A,
  input  logic B,
  input  logic S,
  output logic Y
);

  assign Y = S ? B : A;

endmodule

// File: rtl/mux_4_1_top.sv
// 4:1 multiplexer built three ways (dataflow, structural, behavioural) with a
// registered copy of the behavioural result.
// Optional build macro MUX_4_1_CHECK_EN adds a sticky Mismatch flag that sets
// when the three combinational forms ever disagree on a rising clock edge.
// Reset is asynchronous and active-low; release is expected to be synchronised
// to Clk outside this block.
module mux_4_1_top
  import mux_4_1_pkg::*;
#(
  parameter logic OUT_RST = 1'b0
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic In0,
  input  logic In1,
  input  logic In2,
  input  logic In3,
  input  logic Sel1,
  input  logic Sel0,
  output logic Out_df,
  output logic Out_st,
  output logic Out_bh,
  output logic Out_reg
`ifdef MUX_4_1_CHECK_EN
  ,
  output logic Mismatch
`endif
);

  logic [1:0] sel;
  logic       lo_pair;
  logic       hi_pair;

  assign sel = {Sel1, Sel0};

  // Dataflow form: one sum-of-products term per select value.
  assign Out_df = (~Sel1 & ~Sel0 & In0) |
                  (~Sel1 &  Sel0 & In1) |
                  ( Sel1 & ~Sel0 & In2) |
                  ( Sel1 &  Sel0 & In3);

  // Structural form: Sel0 picks within each pair, Sel1 picks between pairs.
  mux_2_1 u_mux_lo (
    .A (In0),
    .B (In1),
    .S (Sel0),
    .Y (lo_pair)
  );

  mux_2_1 u_mux_hi (
    .A (In2),
    .B (In3),
    .S (Sel0),
    .Y (hi_pair)
  );

  mux_2_1 u_mux_out (
    .A (lo_pair),
    .B (hi_pair),
    .S (Sel1),
    .Y (Out_st)
  );

  // Behavioural form: full decode of the select; the default arm is unreachable
  // for binary selects and is left as X so synthesis may treat it as don't-care.
  always_comb begin
    Out_bh = 1'bx;
    case (sel)
      SEL_IN0: Out_bh = In0;
      SEL_IN1: Out_bh = In1;
      SEL_IN2: Out_bh = In2;
      SEL_IN3: Out_bh = In3;
      default: Out_bh = 1'bx;
    endcase
  end

  // Register the behavioural result once per rising edge; reset forces OUT_RST.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Out_reg <= OUT_RST;
    end else begin
      Out_reg <= Out_bh;
    end
  end

`ifdef MUX_4_1_CHECK_EN
  logic forms_differ;

  assign forms_differ = (Out_df ^ Out_st) | (Out_df ^ Out_bh);

  // Sticky disagreement flag: once any edge sees the forms differ it holds
  // until reset.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Mismatch <= 1'b0;
    end else if (forms_differ) begin
      Mismatch <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_4_1_top.sv
// Directed self-checking bench for mux_4_1_top: reset state, exhaustive
// 64-vector sweep, hold/latency behaviour and asynchronous reset.
// Define MUX_4_1_CHECK_EN to also exercise the Mismatch checker.
module tb_mux_4_1_top;

  localparam logic RST_VAL = 1'b0;

  logic Clk;
  logic Rst_n;
  logic In0, In1, In2, In3;
  logic Sel1, Sel0;
  logic Out_df, Out_st, Out_bh, Out_reg;
`ifdef MUX_4_1_CHECK_EN
  logic Mismatch;
`endif

  int check_count = 0;
  int fail_count  = 0;

  mux_4_1_top #(
    .OUT_RST (RST_VAL)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .In0      (In0),
    .In1      (In1),
    .In2      (In2),
    .In3      (In3),
    .Sel1     (Sel1),
    .Sel0     (Sel0),
    .Out_df   (Out_df),
    .Out_st   (Out_st),
    .Out_bh   (Out_bh),
    .Out_reg  (Out_reg)
`ifdef MUX_4_1_CHECK_EN
    ,
    .Mismatch (Mismatch)
`endif
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    check_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] sel, input logic [3:0] ins);
    {Sel1, Sel0} = sel;
    {In0, In1, In2, In3} = ins;
  endtask

  task automatic checkComb(input string tag, input logic expected);
    checkOutput({tag, "_df"}, Out_df, expected);
    checkOutput({tag, "_st"}, Out_st, expected);
    checkOutput({tag, "_bh"}, Out_bh, expected);
  endtask

  initial begin
    logic [5:0] vec;
    logic       exp_bit;

    // Reset state; combinational outputs must work while in reset.
    Rst_n = 1'b0;
    applyStimulus(2'b01, 4'b0100);
    #2;
    checkOutput("reset_out_reg", Out_reg, RST_VAL);
    checkComb("reset_comb_in1", 1'b1);
    @(posedge Clk); #1;
    checkOutput("reset_hold_edge", Out_reg, RST_VAL);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    checkOutput("first_capture", Out_reg, 1'b1);

    // Exhaustive sweep, 10 ns per step, register checked one edge later.
    for (int i = 0; i < 64; i++) begin
      @(negedge Clk);
      vec = 6'(i);
      Sel1 = vec[5]; Sel0 = vec[4];
      In0 = vec[3]; In1 = vec[2]; In2 = vec[1]; In3 = vec[0];
      case (vec[5:4])
        2'b00:   exp_bit = vec[3];
        2'b01:   exp_bit = vec[2];
        2'b10:   exp_bit = vec[1];
        default: exp_bit = vec[0];
      endcase
      #1;
      checkComb($sformatf("sweep%0d", i), exp_bit);
      @(posedge Clk); #1;
      checkOutput($sformatf("sweep%0d_reg", i), Out_reg, exp_bit);
    end

    // Sel=10 with In0..In3 = 1,1,0,1 selects a zero.
    @(negedge Clk);
    applyStimulus(2'b10, 4'b1101);
    #1;
    checkComb("sel10", 1'b0);
    @(posedge Clk); #1;
    checkOutput("sel10_reg", Out_reg, 1'b0);

    // Sel=11, In3 toggles between edges: comb follows now, register waits.
    @(negedge Clk);
    applyStimulus(2'b11, 4'b0000);
    @(posedge Clk); #1;
    checkOutput("toggle_reg_low", Out_reg, 1'b0);
    @(negedge Clk);
    In3 = 1'b1;
    #1;
    checkComb("toggle_comb", 1'b1);
    checkOutput("toggle_reg_hold", Out_reg, 1'b0);
    @(posedge Clk); #1;
    checkOutput("toggle_reg_cap", Out_reg, 1'b1);

    // Asynchronous reset between edges with Out_reg=1.
    @(negedge Clk); #2;
    Rst_n = 1'b0;
    #1;
    checkOutput("async_rst_reg", Out_reg, RST_VAL);
    checkComb("async_rst_comb", 1'b1);
    @(posedge Clk); #1;
    checkOutput("async_rst_discard", Out_reg, RST_VAL);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    checkOutput("release_no_edge", Out_reg, RST_VAL);
    @(posedge Clk); #1;
    checkOutput("release_capture", Out_reg, 1'b1);

`ifdef MUX_4_1_CHECK_EN
    // Checker: stays clear over a full sweep, then latches a forced fault.
    for (int i = 0; i < 64; i++) begin
      @(negedge Clk);
      vec = 6'(i);
      Sel1 = vec[5]; Sel0 = vec[4];
      In0 = vec[3]; In1 = vec[2]; In2 = vec[1]; In3 = vec[0];
    end
    @(posedge Clk); #1;
    checkOutput("chk_sweep_clear", Mismatch, 1'b0);
    @(negedge Clk);
    applyStimulus(2'b00, 4'b1000);
    force dut.Out_st = 1'b0;
    @(posedge Clk); #1;
    checkOutput("chk_set", Mismatch, 1'b1);
    @(negedge Clk);
    release dut.Out_st;
    @(posedge Clk); #1;
    checkOutput("chk_sticky", Mismatch, 1'b1);
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    checkOutput("chk_reset_clear", Mismatch, 1'b0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    checkOutput("chk_after_reset", Mismatch, 1'b0);
`endif

    $display("%0d/%0d checks passed", check_count - fail_count, check_count);
    $finish;
  end

endmodule
